slf_sweep_checker: RTL and testbench

Hardware self-checker for the simple logic function block F = A(B+C+D'). It drives all 16 input combinations into the function under test in ascending order and samples the returned F after a programmable settle time. Each sample is compared against a golden model. Mismatches are counted and the first failing vector is recorded. The block sits on the response side of the function: it consumes F, and it drives the A/B/C/D stimulus only so it knows which vector each response belongs to. It serves as the on-chip counterpart of the directed sweep bench.

---
 rtl/slf_sweep_checker.sv | 115 +++++++++++
 tb/tb_slf_sweep_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/slf_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | slf_sweep_checker                                                          |
// | Sweeps all 16 A/B/C/D vectors and checks F = A(B+C+D') against golden.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module slf_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       f_in_i,
  output logic [3:0] abcd_out_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [4:0] err_count_o,
  output logic [3:0] first_fail_vec_o,
  output logic       first_fail_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q;
  logic [3:0] vec_q;
  logic [3:0] cnt_q;
  logic [4:0] err_q;
  logic [3:0] ffv_q;
  logic       ffvalid_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic       exp_w;
  logic       mismatch_w;

  assign exp_w      = vec_q[3] & (vec_q[2] | vec_q[1] | ~vec_q[0]);
  assign mismatch_w = f_in_i ^ exp_w;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      vec_q     <= 4'd0;
      cnt_q     <= 4'd0;
      err_q     <= 5'd0;
      ffv_q     <= 4'd0;
      ffvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q   <= S_SETTLE;
            vec_q     <= 4'd0;
            cnt_q     <= CNT_RELOAD;
            err_q     <= 5'd0;
            ffv_q     <= 4'd0;
            ffvalid_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (mismatch_w) begin
            err_q <= err_q + 5'd1;
            if (!ffvalid_q) begin
              ffv_q     <= vec_q;
              ffvalid_q <= 1'b1;
            end
          end
          if (vec_q == 4'd15) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // err_q has not yet absorbed this last sample, so fold it in here
            pass_q  <= (err_q == 5'd0) && !mismatch_w;
          end else begin
            vec_q   <= vec_q + 4'd1;
            cnt_q   <= CNT_RELOAD;
            state_q <= S_SETTLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign abcd_out_o         = vec_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign err_count_o        = err_q;
  assign first_fail_vec_o   = ffv_q;
  assign first_fail_valid_o = ffvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_slf_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_slf_sweep_checker                                                       |
// | Bench for slf_sweep_checker with SETTLE_CYCLES=1 and SETTLE_CYCLES=3.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_slf_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start  [2];
  logic [15:0] tbl    [2];
  logic        f_in   [2];
  logic [3:0]  abcd   [2];
  logic        busy   [2];
  logic        done   [2];
  logic        pass   [2];
  logic [4:0]  err    [2];
  logic [3:0]  ffv    [2];
  logic        ffval  [2];

  int n_checks = 0;
  int n_pass   = 0;

  assign f_in[0] = tbl[0][abcd[0]];
  assign f_in[1] = tbl[1][abcd[1]];

  slf_sweep_checker #(.SETTLE_CYCLES(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .f_in_i(f_in[0]),
    .abcd_out_o(abcd[0]), .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
    .err_count_o(err[0]), .first_fail_vec_o(ffv[0]), .first_fail_valid_o(ffval[0])
  );

  slf_sweep_checker #(.SETTLE_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .f_in_i(f_in[1]),
    .abcd_out_o(abcd[1]), .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
    .err_count_o(err[1]), .first_fail_vec_o(ffv[1]), .first_fail_valid_o(ffval[1])
  );

  // Truth tables of various functions under test (bit v = F for vector v)
  localparam logic [15:0] T_GOOD   = 16'hFD00;
  localparam logic [15:0] T_STUCK0 = 16'h0000;
  localparam logic [15:0] T_STUCK1 = 16'hFFFF;
  localparam logic [15:0] T_NO_INV = 16'hFE00;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", name, i, $time, act, expv);
  endtask

  function automatic logic golden(input int v);
    return v inside {8, 10, 11, 12, 13, 14, 15};
  endfunction

  // Model: sweep progress is just "edges since the accepting edge"
  logic        m_active [2];
  int          m_k      [2];
  logic [15:0] m_tbl    [2];

  function automatic int sweep_len(input int i);
    return 16 * ((i == 0) ? 2 : 4);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] <= 1'b0;
        m_k[i]      <= 0;
        m_tbl[i]    <= 16'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start[i] && (!m_active[i] || m_k[i] >= sweep_len(i))) begin
          m_active[i] <= 1'b1;
          m_k[i]      <= 0;
          m_tbl[i]    <= tbl[i];
        end else if (m_active[i] && m_k[i] < sweep_len(i)) begin
          m_k[i] <= m_k[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   per, n, e_err, e_ffv;
      logic e_busy, e_done, e_ffval;
      int   e_abcd;
      per = sweep_len(i) / 16;
      e_abcd = 0; e_busy = 0; e_done = 0; e_err = 0; e_ffv = 0; e_ffval = 0;
      if (m_active[i]) begin
        e_busy = m_k[i] < sweep_len(i);
        e_done = !e_busy;
        e_abcd = e_busy ? m_k[i] / per : 15;
        n = e_busy ? m_k[i] / per : 16;
        for (int v = 0; v < n; v++) begin
          if (m_tbl[i][v] != golden(v)) begin
            if (!e_ffval) e_ffv = v;
            e_ffval = 1'b1;
            e_err++;
          end
        end
      end
      chk("abcd", i, 32'(abcd[i]), 32'(e_abcd));
      chk("busy", i, 32'(busy[i]), 32'(e_busy));
      chk("done", i, 32'(done[i]), 32'(e_done));
      chk("pass", i, 32'(pass[i]), 32'(e_done && e_err == 0));
      chk("err_count", i, 32'(err[i]), 32'(e_err));
      chk("first_fail_vec", i, 32'(ffv[i]), 32'(e_ffv));
      chk("first_fail_valid", i, 32'(ffval[i]), 32'(e_ffval));
    end
  end

  // Start pulse, then count edges from the accepting edge until done
  task automatic run_sweep(input int i, input logic [15:0] t, output int edges);
    tbl[i] = t;
    @(posedge clk); #2 start[i] = 1'b1;
    @(posedge clk); #2 start[i] = 1'b0;
    edges = 0;
    do begin
      @(posedge clk); #1 edges++;
    end while (!done[i] && edges < 300);
  endtask

  task automatic pin_results(input string tag, input int i, input int edges, input int e_edges,
                             input int e_err, input int e_ffv, input int e_ffval, input int e_pass);
    chk({tag, "_edges"}, i, 32'(edges), 32'(e_edges));
    chk({tag, "_err"},   i, 32'(err[i]), 32'(e_err));
    chk({tag, "_ffv"},   i, 32'(ffv[i]), 32'(e_ffv));
    chk({tag, "_ffval"}, i, 32'(ffval[i]), 32'(e_ffval));
    chk({tag, "_pass"},  i, 32'(pass[i]), 32'(e_pass));
  endtask

  initial begin
    int edges;
    int w;
    start[0] = 0; start[1] = 0;
    tbl[0] = T_GOOD; tbl[1] = T_GOOD;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    run_sweep(0, T_GOOD, edges);
    pin_results("good", 0, edges, 32, 0, 0, 0, 1);
    run_sweep(0, T_STUCK0, edges);
    pin_results("stuck0", 0, edges, 32, 7, 8, 1, 0);
    run_sweep(0, T_STUCK1, edges);
    pin_results("stuck1", 0, edges, 32, 9, 0, 1, 0);
    run_sweep(0, T_NO_INV, edges);
    pin_results("noinv", 0, edges, 32, 2, 8, 1, 0);
    run_sweep(1, T_GOOD, edges);
    pin_results("settle3", 1, edges, 64, 0, 0, 0, 1);

    // start pulsed while busy must not disturb the sweep
    tbl[0] = T_STUCK0;
    @(posedge clk); #2 start[0] = 1'b1;
    @(posedge clk); #2 start[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 start[0] = 1'b1;
    @(posedge clk); #2 start[0] = 1'b0;
    edges = 10;
    do begin
      @(posedge clk); #1 edges++;
    end while (!done[0] && edges < 300);
    pin_results("busystart", 0, edges, 32, 7, 8, 1, 0);

    // asynchronous reset mid-sweep at vector 5
    run_sweep(1, T_STUCK1, edges);
    tbl[0] = T_STUCK1;
    @(posedge clk); #2 start[0] = 1'b1;
    @(posedge clk); #2 start[0] = 1'b0;
    w = 0;
    while (abcd[0] != 4'd5 && w < 100) begin
      @(posedge clk); #2 w++;
    end
    chk("reach_vec5", 0, 32'(abcd[0]), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_async_abcd", 0, 32'(abcd[0]), 32'd0);
    chk("rst_async_err", 0, 32'(err[0]), 32'd0);
    chk("rst_async_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_async_done", 1, 32'(done[1]), 32'd0);
    chk("rst_async_ffval", 0, 32'(ffval[0]), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    run_sweep(0, T_GOOD, edges);
    pin_results("afterrst", 0, edges, 32, 0, 0, 0, 1);

    // randomized functions under test, including restarts straight from DONE
    for (int r = 0; r < 6; r++) begin
      logic [15:0] t;
      int e_err, e_ffv, e_ffval;
      int i;
      t = 16'($urandom);
      i = (r % 3 == 2) ? 1 : 0;
      e_err = 0; e_ffv = 0; e_ffval = 0;
      for (int v = 0; v < 16; v++) begin
        if (t[v] != golden(v)) begin
          if (e_ffval == 0) e_ffv = v;
          e_ffval = 1;
          e_err++;
        end
      end
      run_sweep(i, t, edges);
      pin_results("rand", i, edges, (i == 0) ? 32 : 64, e_err, e_ffv, e_ffval, (e_err == 0) ? 1 : 0);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
